adder_rsp_checker: RTL and testbench
====================================

ADDER_RSP_CHECKER -- requirements
Module: adder_rsp_checker

Interface
REQ-001 The block SHALL have parameter g_data_width, default 8, operand width of the checked adder stream.
REQ-002 The block SHALL have parameter g_depth, default 4, expected-result FIFO depth (power of two, >=2).
REQ-003 The block SHALL have parameter g_cnt_width, default 16, width of match/error counters.
REQ-004 i_clk  input  1  clock, all state updates on rising edge.
REQ-005 i_rst  input  1  reset, asynchronous, active-high.
REQ-006 i_req_valid  input  1  request issued to adder this cycle.
REQ-007 i_req_A  input  g_data_width  request operand A.
REQ-008 i_req_B  input  g_data_width  request operand B.
REQ-009 i_rsp_valid  input  1  adder result valid this cycle.
REQ-010 i_rsp_C  input  g_data_width+1  adder result.
REQ-011 o_pending  output  clog2(g_depth)+1  outstanding expected results in FIFO.
REQ-012 o_match_cnt  output  g_cnt_width  count of correct responses.
REQ-013 o_err_cnt  output  g_cnt_width  count of mismatching responses.
REQ-014 o_err  output  1  sticky: any mismatch, overflow or underflow since reset.
REQ-015 o_overflow  output  1  one-cycle pulse: request dropped, FIFO full.
REQ-016 o_underflow  output  1  one-cycle pulse: response with no expected result.
REQ-017 o_chk_valid  output  1  one-cycle pulse: a comparison completed.
REQ-018 o_chk_ok  output  1  result of last comparison, valid with o_chk_valid, else 0.

Function
REQ-019 On i_req_valid, block SHALL compute A+B zero-extended to g_data_width+1 bits (no truncation) and push it into the FIFO.
REQ-020 On i_rsp_valid with o_pending>0, block SHALL pop the oldest entry and compare with i_rsp_C; in-order only.
REQ-021 Comparison result SHALL appear on o_chk_valid/o_chk_ok the cycle after i_rsp_valid (1-cycle latency, registered).
REQ-022 Match: o_match_cnt +1; mismatch: o_err_cnt +1, o_err set.
REQ-023 Counters SHALL saturate at all-ones, never wrap.
REQ-024 Push with FIFO full and no pop same cycle: entry dropped, o_overflow pulses next cycle, o_err set, o_pending unchanged.
REQ-025 Push and pop same cycle with FIFO full: both SHALL occur, no overflow, o_pending unchanged.
REQ-026 Response with o_pending=0: no pop, no comparison, o_underflow pulses next cycle, o_err set, counters unchanged; a same-cycle push SHALL still be stored (no bypass).
REQ-027 o_pending SHALL be +1 on push only, -1 on pop only, unchanged on both/neither.
REQ-028 FIFO read/write pointers SHALL wrap modulo g_depth; full/empty derived from an extra pointer bit or o_pending.
REQ-029 o_err SHALL clear only by reset.
REQ-030 A correctly connected 1-cycle adder (i_rsp = registered i_req sum) SHALL never cause overflow/underflow/mismatch for g_depth>=2.

Reset
REQ-031 On i_rst assertion, asynchronously: FIFO emptied, o_pending=0, o_match_cnt=0, o_err_cnt=0, o_err=0, o_overflow=0, o_underflow=0, o_chk_valid=0, o_chk_ok=0.
REQ-032 Reset mid-operation SHALL discard all outstanding expected results; first response after release with no new request SHALL raise underflow.
REQ-033 FIFO storage content need not be reset; only pointers/count.

Verification
REQ-034 Req A=0xFF,B=0xFF; next cycle rsp C=0x1FE -> o_chk_valid=1, o_chk_ok=1, o_match_cnt=1, o_err=0.
REQ-035 Req A=3,B=4; rsp C=8 -> o_chk_ok=0, o_err_cnt=1, o_err=1 and stays 1.
REQ-036 Five reqs, no rsp (g_depth=4) -> o_pending=4, one o_overflow pulse; then four correct rsps -> o_match_cnt=4, o_pending=0.
REQ-037 Rsp with empty FIFO plus simultaneous req 1+1 -> o_underflow pulse, o_pending=1; next rsp C=2 -> match.
REQ-038 FIFO full, simultaneous req and correct rsp for 10 cycles -> o_pending stays 4, no overflow, o_match_cnt=10, pointers wrap.
REQ-039 Two reqs outstanding, assert i_rst mid-cycle -> all outputs 0 immediately; rsp after release -> underflow.

Source files
------------

// File: rtl/adder_rsp_checker.sv
// Scoreboard for a streaming adder: expected sums are queued on request and
// compared in order against the adder's responses, with counters and error flags.
module adder_rsp_checker #(
    parameter int g_data_width = 8,
    parameter int g_depth      = 4,
    parameter int g_cnt_width  = 16
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_req_valid,
    input  logic [g_data_width-1:0]     i_req_A,
    input  logic [g_data_width-1:0]     i_req_B,
    input  logic                        i_rsp_valid,
    input  logic [g_data_width:0]       i_rsp_C,
    output logic [$clog2(g_depth):0]    o_pending,
    output logic [g_cnt_width-1:0]      o_match_cnt,
    output logic [g_cnt_width-1:0]      o_err_cnt,
    output logic                        o_err,
    output logic                        o_overflow,
    output logic                        o_underflow,
    output logic                        o_chk_valid,
    output logic                        o_chk_ok
);

    localparam int AW = $clog2(g_depth);
    localparam logic [AW:0]            DEPTH_CNT = (AW+1)'(g_depth);
    localparam logic [AW:0]            PEND_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0]          PTR_ONE   = AW'(1);
    localparam logic [g_cnt_width-1:0] CNT_ONE   = g_cnt_width'(1);

    logic [g_data_width:0]   mem [g_depth];
    logic [AW-1:0]           wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]           rd_ptr_reg, rd_ptr_next;
    logic [AW:0]             pending_reg, pending_next;
    logic [g_cnt_width-1:0]  match_cnt_reg, match_cnt_next;
    logic [g_cnt_width-1:0]  err_cnt_reg, err_cnt_next;
    logic                    err_reg, err_next;
    logic                    overflow_reg, overflow_next;
    logic                    underflow_reg, underflow_next;
    logic                    chk_valid_reg, chk_valid_next;
    logic                    chk_ok_reg, chk_ok_next;

    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    do_pop;
    logic                    do_push;
    logic                    cmp_equal;
    logic [g_data_width:0]   req_sum;

    assign req_sum    = {1'b0, i_req_A} + {1'b0, i_req_B};
    assign fifo_full  = (pending_reg == DEPTH_CNT);
    assign fifo_empty = (pending_reg == '0);
    assign do_pop     = i_rsp_valid && !fifo_empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    assign do_push    = i_req_valid && (!fifo_full || do_pop);
    assign cmp_equal  = (mem[rd_ptr_reg] == i_rsp_C);

    always_comb begin
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        pending_next   = pending_reg;
        match_cnt_next = match_cnt_reg;
        err_cnt_next   = err_cnt_reg;
        err_next       = err_reg;
        overflow_next  = i_req_valid && fifo_full && !do_pop;
        underflow_next = i_rsp_valid && fifo_empty;
        chk_valid_next = do_pop;
        chk_ok_next    = do_pop && cmp_equal;

        if (do_push) begin
            wr_ptr_next = wr_ptr_reg + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_next = rd_ptr_reg + PTR_ONE;
        end
        if (do_push && !do_pop) begin
            pending_next = pending_reg + PEND_ONE;
        end else if (!do_push && do_pop) begin
            pending_next = pending_reg - PEND_ONE;
        end

        if (do_pop) begin
            if (cmp_equal) begin
                if (match_cnt_reg != '1) begin
                    match_cnt_next = match_cnt_reg + CNT_ONE;
                end
            end else begin
                if (err_cnt_reg != '1) begin
                    err_cnt_next = err_cnt_reg + CNT_ONE;
                end
                err_next = 1'b1;
            end
        end
        if (overflow_next || underflow_next) begin
            err_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            pending_reg   <= '0;
            match_cnt_reg <= '0;
            err_cnt_reg   <= '0;
            err_reg       <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            chk_valid_reg <= 1'b0;
            chk_ok_reg    <= 1'b0;
        end else begin
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            pending_reg   <= pending_next;
            match_cnt_reg <= match_cnt_next;
            err_cnt_reg   <= err_cnt_next;
            err_reg       <= err_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
            chk_valid_reg <= chk_valid_next;
            chk_ok_reg    <= chk_ok_next;
        end
    end

    // Storage needs no reset: only pointers and occupancy define what is valid.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= req_sum;
        end
    end

    assign o_pending   = pending_reg;
    assign o_match_cnt = match_cnt_reg;
    assign o_err_cnt   = err_cnt_reg;
    assign o_err       = err_reg;
    assign o_overflow  = overflow_reg;
    assign o_underflow = underflow_reg;
    assign o_chk_valid = chk_valid_reg;
    assign o_chk_ok    = chk_ok_reg;

endmodule

// File: tb/tb_adder_rsp_checker.sv
// Directed and randomized bench for adder_rsp_checker against a queue-based
// model of the expected-result stream.
module tb_adder_rsp_checker;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            i_clk = 1'b0;
    logic            i_rst = 1'b1;
    logic            i_req_valid = 1'b0;
    logic [W-1:0]    i_req_A = '0;
    logic [W-1:0]    i_req_B = '0;
    logic            i_rsp_valid = 1'b0;
    logic [W:0]      i_rsp_C = '0;
    logic [$clog2(D):0] o_pending;
    logic [CW-1:0]   o_match_cnt;
    logic [CW-1:0]   o_err_cnt;
    logic            o_err;
    logic            o_overflow;
    logic            o_underflow;
    logic            o_chk_valid;
    logic            o_chk_ok;

    adder_rsp_checker #(
        .g_data_width (W),
        .g_depth      (D),
        .g_cnt_width  (CW)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_valid (i_req_valid),
        .i_req_A     (i_req_A),
        .i_req_B     (i_req_B),
        .i_rsp_valid (i_rsp_valid),
        .i_rsp_C     (i_rsp_C),
        .o_pending   (o_pending),
        .o_match_cnt (o_match_cnt),
        .o_err_cnt   (o_err_cnt),
        .o_err       (o_err),
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow),
        .o_chk_valid (o_chk_valid),
        .o_chk_ok    (o_chk_ok)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: a queue of expected sums plus the observable flags.
    int q[$];
    int m_match, m_errc;
    bit m_err, m_ovf, m_unf, m_cv, m_ok;
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check({ctx, ".pending"},   32'(o_pending),   32'(q.size()));
        check({ctx, ".match_cnt"}, 32'(o_match_cnt), 32'(m_match));
        check({ctx, ".err_cnt"},   32'(o_err_cnt),   32'(m_errc));
        check({ctx, ".err"},       32'(o_err),       32'(m_err));
        check({ctx, ".overflow"},  32'(o_overflow),  32'(m_ovf));
        check({ctx, ".underflow"}, 32'(o_underflow), 32'(m_unf));
        check({ctx, ".chk_valid"}, 32'(o_chk_valid), 32'(m_cv));
        check({ctx, ".chk_ok"},    32'(o_chk_ok),    32'(m_ok));
    endtask

    task automatic model_reset();
        q.delete();
        m_match = 0; m_errc = 0;
        m_err = 0; m_ovf = 0; m_unf = 0; m_cv = 0; m_ok = 0;
    endtask

    task automatic step(input string ctx, input bit req, input int a, input int b,
                        input bit rsp, input int c);
        int e;
        i_req_valid = req;
        i_req_A     = W'(a);
        i_req_B     = W'(b);
        i_rsp_valid = rsp;
        i_rsp_C     = (W+1)'(c);
        @(posedge i_clk);
        m_cv = 0; m_ok = 0; m_ovf = 0; m_unf = 0;
        if (rsp) begin
            if (q.size() > 0) begin
                e    = q.pop_front();
                m_cv = 1;
                m_ok = (e == (c & ((1 << (W+1)) - 1)));
                if (m_ok) begin
                    if (m_match < CMAX) m_match++;
                end else begin
                    if (m_errc < CMAX) m_errc++;
                    m_err = 1;
                end
            end else begin
                m_unf = 1;
                m_err = 1;
            end
        end
        if (req) begin
            if (q.size() < D) q.push_back((a & 255) + (b & 255));
            else begin
                m_ovf = 1;
                m_err = 1;
            end
        end
        #1;
        check_all(ctx);
        i_req_valid = 1'b0;
        i_rsp_valid = 1'b0;
    endtask

    // Asynchronous reset asserted away from any clock edge.
    task automatic do_reset(input string ctx);
        #2;
        i_rst = 1'b1;
        #1;
        model_reset();
        check_all(ctx);
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b0;
    endtask

    function automatic int gen_a(input int k);
        return (k * 17 + 5) & 255;
    endfunction

    function automatic int gen_b(input int k);
        return (k * 29 + 200) & 255;
    endfunction

    initial begin
        int c;
        bit prev_req;
        int prev_sum;
        bit r;
        int a, b;

        model_reset();
        #1;
        check_all("reset");
        @(negedge i_clk);
        i_rst = 1'b0;

        // Maximum operands: sum needs the extra bit.
        step("max_req", 1, 255, 255, 0, 0);
        step("max_rsp", 0, 0, 0, 1, 'h1FE);

        // Wrong response; sticky error must persist.
        step("bad_req", 1, 3, 4, 0, 0);
        step("bad_rsp", 0, 0, 0, 1, 8);
        step("bad_idle1", 0, 0, 0, 0, 0);
        step("bad_idle2", 0, 0, 0, 0, 0);

        // Five requests into a depth-4 FIFO, then drain.
        do_reset("rst_a");
        for (int i = 0; i < 5; i++) step("fill", 1, i + 1, i + 2, 0, 0);
        step("fill_idle", 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("drain", 0, 0, 0, 1, 2 * i + 3);

        // Response on empty FIFO with a simultaneous request.
        do_reset("rst_b");
        step("unf_push", 1, 1, 1, 1, 0);
        step("unf_next", 0, 0, 0, 1, 2);

        // Full FIFO with push+pop every cycle; pointers wrap.
        do_reset("rst_c");
        for (int k = 0; k < D; k++) step("full_fill", 1, gen_a(k), gen_b(k), 0, 0);
        for (int k = D; k < D + 10; k++)
            step("full_pp", 1, gen_a(k), gen_b(k), 1, gen_a(k - D) + gen_b(k - D));

        // Reset mid-operation discards outstanding results.
        do_reset("rst_d");
        step("mid_req1", 1, 10, 20, 0, 0);
        step("mid_req2", 1, 30, 40, 0, 0);
        do_reset("rst_mid");
        step("post_rst_rsp", 0, 0, 0, 1, 30);

        // Behaves like a well-connected one-cycle adder.
        do_reset("rst_e");
        prev_req = 0;
        prev_sum = 0;
        for (int i = 0; i < 60; i++) begin
            r = 1'($urandom_range(0, 1));
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            step("pipe", r, a, b, prev_req, prev_sum);
            prev_req = r;
            prev_sum = a + b;
        end

        // Random traffic: mix of correct, wrong and unsolicited responses.
        for (int i = 0; i < 400; i++) begin
            r = 1'($urandom_range(0, 1));
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 255));
            if (q.size() > 0 && $urandom_range(0, 3) != 0) c = q[0];
            else c = int'($urandom_range(0, 511));
            step("rand", r, a, b, 1'($urandom_range(0, 1)), c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
